exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle control sequencer for the 8-bit accumulator CPU. Sits between the instruction decoder and the datapath: gates the decoder's raw enable requests (register write, accumulator write, data-memory read/write, program-counter load) into a fixed FETCH/DECODE/MEM/EXEC/WB sequence. Handles a memory ready handshake with timeout, free-run and single-step control, and halt. Counts retired instructions.

## Interface
Parameters:
- MEM_WAIT_MAX, 7: maximum consecutive MEM cycles with mem_ready low before timeout.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run instructions back to back.
- step  in  1  one-cycle pulse; executes exactly one instruction when run=0.
- dec_reg_ce  in  1  decoder request: write register file.
- dec_aku_en  in  1  decoder request: write accumulator.
- dec_mem_rd  in  1  decoder request: data-memory read feeds ALU.
- dec_mem_wr  in  1  decoder request: data-memory write of accumulator.
- dec_pc_load  in  1  decoder request: jump (load PC).
- dec_halt  in  1  decoder: halt instruction.
- mem_ready  in  1  data memory completes the current access.
- ir_load  out  1  latch program-memory output into instruction register.
- pc_inc  out  1  increment PC.
- pc_load  out  1  load PC from decoder jump address.
- reg_ce  out  1  gated register-file write enable.
- aku_en  out  1  gated accumulator write enable.
- mem_rd  out  1  gated data-memory read.
- mem_wr  out  1  gated data-memory write.
- state  out  3  current state encoding.
- halted  out  1  in HALT.
- busy  out  1  state not IDLE and not HALT.
- mem_timeout  out  1  sticky timeout flag.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 unused; it goes to HALT.
- IDLE: run=1 → FETCH. When run=0, step=1 → FETCH. If run and step are both 1, step is ignored. A step pulse in any other state is ignored, not queued.
- FETCH: ir_load=1 → DECODE.
- DECODE: dec_halt → HALT; else dec_mem_rd|dec_mem_wr → MEM; else → EXEC. dec_halt has priority. dec_mem_rd and dec_mem_wr both set is treated as read.
- MEM: mem_rd or mem_wr is held high every MEM cycle.
  - mem_ready=1 → EXEC (read) or WB (write).
  - Wait counter clears on MEM entry and increments per cycle with mem_ready=0.
  - Counter == MEM_WAIT_MAX with mem_ready=0 → HALT and set mem_timeout.
  - mem_ready=1 in that same cycle wins.
- EXEC: aku_en = dec_aku_en → WB.
- WB:
  - reg_ce = dec_reg_ce.
  - pc_load = dec_pc_load; pc_inc = !dec_pc_load.
  - instr_count increments.
  - Next state: run=1 → FETCH, else IDLE.
- HALT: halted=1; all enables 0. Only clr exits HALT.
- Outputs are decoded combinationally from the state register and the dec_* inputs. No enable is ever high outside its own state.
- run falling mid-instruction: the instruction completes through WB, then IDLE.

## Timing
- Reset (clr=0, async): state=IDLE, instr_count=0, mem_timeout=0, wait counter=0. All enables 0, halted=0, busy=0.
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory write: 4 + N wait cycles (FETCH, DECODE, MEM, WB).
- Memory read: 5 + N cycles.
- dec_* are driven from the instruction register. They are stable from DECODE through WB.
- instr_count updates on the clock edge leaving WB.
- Timeout fires on the edge after MEM_WAIT_MAX+1 consecutive not-ready MEM cycles.

## Structure
- A shared package cpu_pkg holds:
  - the seq_state_t enum with the encodings above;
  - the default constants MEM_WAIT_MAX and CNT_W.
- One sub-module, mem_wait_timer, contains the wait counter with clear/enable inputs and a limit_hit output. Everything else stays in exec_sequencer.

## Test plan
- Reset: hold clr=0 mid-MEM → state=0, enables 0, instr_count=0. Release clr, run=1, ALU op (dec_aku_en=1, dec_reg_ce=1) → aku_en high in cycle 3, reg_ce/pc_inc high in cycle 4, instr_count=1.
- Free-run: 3 non-memory instructions → FETCH recurs every 4 cycles, instr_count=3 after 12 cycles.
- Single-step: run=0, step pulse → one instruction then IDLE. Step pulses during EXEC are ignored; instr_count=1.
- Memory read: mem_ready low for 2 cycles → mem_rd high 3 cycles, then EXEC with aku_en=1, total 7 cycles. Write variant → 6 cycles, mem_wr high 3 cycles.
- Timeout: mem_ready stuck 0 → HALT after 8 MEM cycles, mem_timeout=1, halted=1. Then run/step ignored until clr.
- Jump plus halt: dec_pc_load=1 → pc_load=1, pc_inc=0 in WB. Next instruction with dec_halt=1 and dec_mem_wr=1 → HALT directly from DECODE, mem_wr never asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: sequencer state
// encodings and default sizing constants.
package cpu_pkg;

    localparam int MEM_WAIT_MAX = 7;
    localparam int CNT_W        = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Decoder/memory/datapath signal bundle around the execution sequencer.
// master = decoder + memory + datapath side, slave = the sequencer.
interface exec_sequencer_if #(
    parameter int CNT_W = cpu_pkg::CNT_W
);
    logic             run;
    logic             step;
    logic             dec_reg_ce;
    logic             dec_aku_en;
    logic             dec_mem_rd;
    logic             dec_mem_wr;
    logic             dec_pc_load;
    logic             dec_halt;
    logic             mem_ready;

    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic             reg_ce;
    logic             aku_en;
    logic             mem_rd;
    logic             mem_wr;
    logic [2:0]       state;
    logic             halted;
    logic             busy;
    logic             mem_timeout;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, step, dec_reg_ce, dec_aku_en, dec_mem_rd, dec_mem_wr,
               dec_pc_load, dec_halt, mem_ready,
        input  ir_load, pc_inc, pc_load, reg_ce, aku_en, mem_rd, mem_wr,
               state, halted, busy, mem_timeout, instr_count
    );

    modport slave (
        input  run, step, dec_reg_ce, dec_aku_en, dec_mem_rd, dec_mem_wr,
               dec_pc_load, dec_halt, mem_ready,
        output ir_load, pc_inc, pc_load, reg_ce, aku_en, mem_rd, mem_wr,
               state, halted, busy, mem_timeout, instr_count
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles; limit_hit flags the last
// cycle the sequencer is allowed to keep waiting.
module mem_wait_timer #(
    parameter int LIMIT = cpu_pkg::MEM_WAIT_MAX
) (
    input  logic clk,
    input  logic clr,
    input  logic cnt_clr,
    input  logic cnt_en,
    output logic limit_hit
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // Saturates at the limit so a stalled count can never wrap back to zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                        cnt <= '0;
        else if (cnt_clr)                cnt <= '0;
        else if (cnt_en && !limit_hit)   cnt <= cnt + 1'b1;
    end

    assign limit_hit = (cnt == W'(LIMIT));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC/WB sequencer: gates decoder enable
// requests into their own phase, handles memory wait/timeout and halt.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = cpu_pkg::MEM_WAIT_MAX,
    parameter int CNT_W        = cpu_pkg::CNT_W
) (
    input logic             clk,
    input logic             clr,
    exec_sequencer_if.slave bus
);

    seq_state_t       state_q, state_d;
    logic             in_mem;
    logic             limit_hit;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] count_q;

    assign in_mem = (state_q == S_MEM);

    mem_wait_timer #(.LIMIT(MEM_WAIT_MAX)) u_wait (
        .clk       (clk),
        .clr       (clr),
        .cnt_clr   (!in_mem),
        .cnt_en    (in_mem && !bus.mem_ready),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.run || bus.step) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.dec_halt)                          state_d = S_HALT;
                else if (bus.dec_mem_rd || bus.dec_mem_wr) state_d = S_MEM;
                else                                       state_d = S_EXEC;
            end
            // A ready response in the limit cycle still completes the access.
            S_MEM: begin
                if (bus.mem_ready)  state_d = bus.dec_mem_rd ? S_EXEC : S_WB;
                else if (limit_hit) state_d = S_HALT;
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = bus.run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        bus.ir_load = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.pc_load = 1'b0;
        bus.reg_ce  = 1'b0;
        bus.aku_en  = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        case (state_q)
            S_FETCH: bus.ir_load = 1'b1;
            S_MEM: begin
                bus.mem_rd = bus.dec_mem_rd;
                bus.mem_wr = bus.dec_mem_wr && !bus.dec_mem_rd;
            end
            S_EXEC:  bus.aku_en = bus.dec_aku_en;
            S_WB: begin
                bus.reg_ce  = bus.dec_reg_ce;
                bus.pc_load = bus.dec_pc_load;
                bus.pc_inc  = !bus.dec_pc_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_timeout_q <= 1'b0;
            count_q       <= '0;
        end else begin
            if (in_mem && !bus.mem_ready && limit_hit) mem_timeout_q <= 1'b1;
            if (state_q == S_WB)                       count_q <= count_q + 1'b1;
        end
    end

    assign bus.state       = state_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected phase
// list from the sequencing rules, then compared cycle by cycle.
module tb_exec_sequencer;

    localparam int MAXW = 7;
    localparam int CW   = 16;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_HALT = 6;

    typedef struct packed {
        logic halt, pc_load, mem_wr, mem_rd, aku_en, reg_ce;
    } instr_t;

    logic          clk = 1'b0;
    logic          clr;
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] model_count;
    logic          model_to;

    exec_sequencer_if #(.CNT_W(CW)) bus();

    exec_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {state, ir_load, pc_inc, pc_load, reg_ce, aku_en, mem_rd, mem_wr, halted, busy}
    function automatic logic [11:0] exp_vec(int ph, instr_t ins);
        logic [11:0] v;
        v = '0;
        v[11:9] = 3'(ph);
        case (ph)
            P_FETCH: v[8] = 1'b1;
            P_MEM:   begin v[3] = ins.mem_rd; v[2] = ins.mem_wr & ~ins.mem_rd; end
            P_EXEC:  v[4] = ins.aku_en;
            P_WB:    begin v[5] = ins.reg_ce; v[6] = ins.pc_load; v[7] = ~ins.pc_load; end
            default: ;
        endcase
        v[1] = (ph == P_HALT);
        v[0] = (ph != P_IDLE) && (ph != P_HALT);
        return v;
    endfunction

    function automatic logic [11:0] got_vec();
        return {bus.state, bus.ir_load, bus.pc_inc, bus.pc_load, bus.reg_ce,
                bus.aku_en, bus.mem_rd, bus.mem_wr, bus.halted, bus.busy};
    endfunction

    function automatic instr_t rand_instr(logic allow_mem);
        instr_t i;
        i = 6'($urandom);
        i.halt = 1'b0;
        if (!allow_mem) begin i.mem_rd = 1'b0; i.mem_wr = 1'b0; end
        return i;
    endfunction

    task automatic drive_dec(input instr_t ins);
        bus.dec_reg_ce  = ins.reg_ce;
        bus.dec_aku_en  = ins.aku_en;
        bus.dec_mem_rd  = ins.mem_rd;
        bus.dec_mem_wr  = ins.mem_wr;
        bus.dec_pc_load = ins.pc_load;
        bus.dec_halt    = ins.halt;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // One cycle parked in IDLE or HALT with the given run/step levels.
    task automatic quiet_cycle(input int ph, input logic run_v, input logic step_v);
        logic [11:0] got;
        bus.run = run_v;
        bus.step = step_v;
        bus.mem_ready = 1'($urandom_range(0, 1));
        drive_dec(6'($urandom));
        #1;
        got = got_vec();
        checks++;
        if (got !== exp_vec(ph, '0)) begin
            failures++;
            $display("FAIL quiet_state%0d: outputs got %h want %h", ph, got, exp_vec(ph, '0));
        end
        checks++;
        if (bus.instr_count !== model_count) begin
            failures++;
            $display("FAIL quiet_count: got %0d want %0d", bus.instr_count, model_count);
        end
        checks++;
        if (bus.mem_timeout !== model_to) begin
            failures++;
            $display("FAIL quiet_timeout: got %b want %b", bus.mem_timeout, model_to);
        end
        advance();
        bus.step = 1'b0;
    endtask

    // Starts with the DUT in FETCH; waits < 0 means memory never answers.
    task automatic exec_instr(input instr_t ins, input int waits,
                              input logic run_v, input logic step_exec);
        int          ph[$];
        int          mcnt;
        logic [11:0] got, want;
        mcnt = 0;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (ins.halt) ph.push_back(P_HALT);
        else if (ins.mem_rd || ins.mem_wr) begin
            if (waits < 0 || waits > MAXW) begin
                for (int i = 0; i <= MAXW; i++) ph.push_back(P_MEM);
                ph.push_back(P_HALT);
            end else begin
                for (int i = 0; i <= waits; i++) ph.push_back(P_MEM);
                if (ins.mem_rd) ph.push_back(P_EXEC);
                ph.push_back(P_WB);
            end
        end else begin
            ph.push_back(P_EXEC);
            ph.push_back(P_WB);
        end
        foreach (ph[k]) begin
            drive_dec(ins);
            bus.run  = run_v;
            bus.step = step_exec && (ph[k] == P_EXEC);
            bus.mem_ready = (ph[k] == P_MEM) ? (mcnt == waits) : 1'($urandom_range(0, 1));
            if (ph[k] == P_HALT && k > 0 && ph[k-1] == P_MEM) model_to = 1'b1;
            #1;
            got  = got_vec();
            want = exp_vec(ph[k], ins);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL trace[%0d] ins=%b: outputs got %h want %h", k, ins, got, want);
            end
            checks++;
            if (bus.instr_count !== model_count) begin
                failures++;
                $display("FAIL trace_count[%0d]: got %0d want %0d", k, bus.instr_count, model_count);
            end
            checks++;
            if (bus.mem_timeout !== model_to) begin
                failures++;
                $display("FAIL trace_timeout[%0d]: got %b want %b", k, bus.mem_timeout, model_to);
            end
            if (ph[k] == P_MEM) mcnt++;
            if (ph[k] == P_WB)  model_count++;
            advance();
        end
        bus.step = 1'b0;
    endtask

    task automatic apply_reset();
        clr = 1'b0;
        advance();
        clr = 1'b1;
        model_count = '0;
        model_to = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (got_vec() !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", got_vec(), 12'h000);
        end
        checks++;
        if (bus.instr_count !== '0 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: count %0d timeout %b want 0 0", bus.instr_count, bus.mem_timeout);
        end
    endtask

    task automatic test_alu_op();
        instr_t ins;
        ins = '0;
        ins.aku_en = 1'b1;
        ins.reg_ce = 1'b1;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        exec_instr(ins, 0, 1'b0, 1'b0);
        quiet_cycle(P_IDLE, 1'b0, 1'b0);
    endtask

    task automatic test_free_run();
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) exec_instr(rand_instr(1'b0), 0, n != 2, 1'b0);
        quiet_cycle(P_IDLE, 1'b0, 1'b0);
    endtask

    task automatic test_single_step();
        quiet_cycle(P_IDLE, 1'b0, 1'b1);
        exec_instr(rand_instr(1'b0), 0, 1'b0, 1'b1);
        quiet_cycle(P_IDLE, 1'b0, 1'b0);
        quiet_cycle(P_IDLE, 1'b1, 1'b1);
        exec_instr(rand_instr(1'b0), 0, 1'b0, 1'b1);
    endtask

    task automatic test_mem();
        instr_t ins;
        ins = '0; ins.mem_rd = 1'b1; ins.aku_en = 1'b1;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        exec_instr(ins, 2, 1'b0, 1'b0);
        ins = '0; ins.mem_wr = 1'b1;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        exec_instr(ins, 2, 1'b0, 1'b0);
        ins = '0; ins.mem_rd = 1'b1; ins.mem_wr = 1'b1; ins.aku_en = 1'b1;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        exec_instr(ins, MAXW, 1'b1, 1'b0);
        ins = '0; ins.mem_wr = 1'b1; ins.reg_ce = 1'b1;
        exec_instr(ins, MAXW, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        instr_t ins;
        int     w;
        logic   r;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            ins = rand_instr(1'b1);
            w   = $urandom_range(0, MAXW);
            r   = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            exec_instr(ins, w, r, 1'($urandom_range(0, 1)));
            if (!r && n != 39) begin
                if ($urandom_range(0, 1) == 1) quiet_cycle(P_IDLE, 1'b0, 1'b0);
                case ($urandom_range(0, 2))
                    0:       quiet_cycle(P_IDLE, 1'b1, 1'b0);
                    1:       quiet_cycle(P_IDLE, 1'b0, 1'b1);
                    default: quiet_cycle(P_IDLE, 1'b1, 1'b1);
                endcase
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        instr_t ins;
        ins = '0; ins.mem_rd = 1'b1;
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        drive_dec(ins);
        bus.mem_ready = 1'b0;
        repeat (3) advance();
        checks++;
        if (bus.state !== 3'd4 || bus.mem_rd !== 1'b1 || bus.instr_count !== model_count) begin
            failures++;
            $display("FAIL pre_reset_mem: state %0d mem_rd %b count %0d want 4 1 %0d",
                     bus.state, bus.mem_rd, bus.instr_count, model_count);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (got_vec() !== 12'h000 || bus.instr_count !== '0 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mem: outputs %h count %0d timeout %b want 000 0 0",
                     got_vec(), bus.instr_count, bus.mem_timeout);
        end
        advance();
        clr = 1'b1;
        model_count = '0;
        model_to = 1'b0;
        quiet_cycle(P_IDLE, 1'b0, 1'b0);
    endtask

    task automatic test_jump_halt();
        instr_t ins;
        ins = '0; ins.pc_load = 1'b1; ins.reg_ce = 1'($urandom_range(0, 1));
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        exec_instr(ins, 0, 1'b1, 1'b0);
        ins = '0; ins.halt = 1'b1; ins.mem_wr = 1'b1;
        exec_instr(ins, 0, 1'b1, 1'b0);
        quiet_cycle(P_HALT, 1'b1, 1'b0);
        quiet_cycle(P_HALT, 1'b0, 1'b1);
        quiet_cycle(P_HALT, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        instr_t ins;
        apply_reset();
        quiet_cycle(P_IDLE, 1'b1, 1'b0);
        ins = rand_instr(1'b1);
        ins.mem_rd = 1'b1;
        exec_instr(ins, -1, 1'b1, 1'b0);
        quiet_cycle(P_HALT, 1'b1, 1'b0);
        quiet_cycle(P_HALT, 1'b0, 1'b1);
        clr = 1'b0;
        #1;
        checks++;
        if (bus.mem_timeout !== 1'b0 || bus.state !== 3'd0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: timeout %b state %0d halted %b want 0 0 0",
                     bus.mem_timeout, bus.state, bus.halted);
        end
        advance();
        clr = 1'b1;
        model_count = '0;
        model_to = 1'b0;
        quiet_cycle(P_IDLE, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clr = 1'b0;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.mem_ready = 1'b0;
        drive_dec('0);
        model_count = '0;
        model_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        clr = 1'b1;
        test_alu_op();
        test_free_run();
        test_single_step();
        test_mem();
        test_back_to_back();
        test_reset_mid_mem();
        test_jump_halt();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
